// File: rtl/block_ram_pkg.sv
// Shared constants and types for the byte-writable block RAM.
package block_ram_pkg;

   // Read-during-write behaviour selectors for the WR_MODE parameter
   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;
   localparam int NO_CHANGE   = 2;

   // Clear sequencer states
   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

endpackage

// File: rtl/block_ram_clear_seq.sv
// Clear sequencer: walks every word address once, writing zero, while
// holding busy high so the access port is locked out.
module block_ram_clear_seq
   import block_ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 7,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_req,
   output logic                busy,
   output logic                clr_we,
   output logic [ADDR_W-1:0]   clr_addr,
   output logic [DATA_W/8-1:0] clr_be,
   output logic [DATA_W-1:0]   clr_data
);

   clr_state_t          state;
   logic [ADDR_W-1:0]   cnt;

   // State and address counter; the clear ends when the counter wraps
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (clr_req) state <= CLEAR;
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy     = (state == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt;
   assign clr_be   = '1;
   assign clr_data = '0;

endmodule

// File: rtl/block_ram_bytewise.sv
// Single-port synchronous RAM with byte write enables, selectable
// read-during-write mode, optional output register and a clear sequencer.
module block_ram_bytewise
   import block_ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 7,
   parameter int OUT_REG        = 0,
   parameter int WR_MODE        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clka,
   input  logic                rsta_n,
   input  logic                ena,
   input  logic [DATA_W/8-1:0] wea,
   input  logic [ADDR_W-1:0]   addra,
   input  logic [DATA_W-1:0]   dina,
   output logic [DATA_W-1:0]   douta,
   output logic                valida,
   input  logic                clr_req,
   output logic                busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                clr_we;
   logic [ADDR_W-1:0]   clr_addr;
   logic [NB-1:0]       clr_be;
   logic [DATA_W-1:0]   clr_data;

   logic                accept;
   logic                wr_any;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [NB-1:0]       wr_be;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W-1:0]   old_word;
   logic [DATA_W-1:0]   merged;

   logic [DATA_W-1:0]   rd_q;
   logic                rd_v;

   block_ram_clear_seq #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear (
      .clk      (clka),
      .rst_n    (rsta_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_be   (clr_be),
      .clr_data (clr_data)
   );

   assign accept = ena && !busy;
   assign wr_any = |wea;

   // The clear sequencer owns the write port whenever it is busy; accesses
   // are never accepted then, so the two sources cannot collide.
   assign wr_en   = clr_we || (accept && wr_any);
   assign wr_addr = clr_we ? clr_addr : addra;
   assign wr_be   = clr_we ? clr_be   : wea;
   assign wr_data = clr_we ? clr_data : dina;

   assign old_word = mem[addra];

   // Word as it will look after the write: new bytes where enabled
   always_comb begin
      merged = old_word;
      for (int unsigned i = 0; i < NB; i++) begin
         if (wea[i]) merged[8*i +: 8] = dina[8*i +: 8];
      end
   end

   // Byte-granular array write; contents are deliberately not reset
   always_ff @(posedge clka) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Read stage with read-during-write mode selection
   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         rd_q <= '0;
         rd_v <= 1'b0;
      end else begin
         rd_v <= accept && !(wr_any && (WR_MODE == NO_CHANGE));
         if (accept) begin
            if (!wr_any || (WR_MODE == READ_FIRST)) rd_q <= old_word;
            else if (WR_MODE == WRITE_FIRST)        rd_q <= merged;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] out_q;
         logic              out_v;

         // Extra output register; holds data between results
         always_ff @(posedge clka) begin
            if (!rsta_n) begin
               out_q <= '0;
               out_v <= 1'b0;
            end else begin
               out_v <= rd_v;
               if (rd_v) out_q <= rd_q;
            end
         end

         assign douta  = out_q;
         assign valida = out_v;
      end else begin : g_noreg
         assign douta  = rd_q;
         assign valida = rd_v;
      end
   endgenerate

endmodule

// File: tb/tb_block_ram_bytewise.sv
// Directed bench for block_ram_bytewise: four CLEAR_ON_RESET instances
// (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+OUT_REG) plus one
// without reset clear, all sharing the same stimulus.
module tb_block_ram_bytewise;

   logic        clk;
   logic        rsta_n;
   logic        ena;
   logic [3:0]  wea;
   logic [6:0]  addra;
   logic [31:0] dina;
   logic        clr_req;

   logic [31:0] douta [5];
   logic        valida [5];
   logic        busy [5];

   int total = 0;
   int bad   = 0;
   int n;

   block_ram_bytewise #(.DATA_W(32), .ADDR_W(7), .OUT_REG(0), .WR_MODE(0), .CLEAR_ON_RESET(1)) d0 (
      .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[0]), .valida(valida[0]), .clr_req(clr_req), .busy(busy[0]));
   block_ram_bytewise #(.DATA_W(32), .ADDR_W(7), .OUT_REG(0), .WR_MODE(1), .CLEAR_ON_RESET(1)) d1 (
      .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[1]), .valida(valida[1]), .clr_req(clr_req), .busy(busy[1]));
   block_ram_bytewise #(.DATA_W(32), .ADDR_W(7), .OUT_REG(0), .WR_MODE(2), .CLEAR_ON_RESET(1)) d2 (
      .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[2]), .valida(valida[2]), .clr_req(clr_req), .busy(busy[2]));
   block_ram_bytewise #(.DATA_W(32), .ADDR_W(7), .OUT_REG(1), .WR_MODE(0), .CLEAR_ON_RESET(1)) d3 (
      .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[3]), .valida(valida[3]), .clr_req(clr_req), .busy(busy[3]));
   block_ram_bytewise #(.DATA_W(32), .ADDR_W(7), .OUT_REG(0), .WR_MODE(0), .CLEAR_ON_RESET(0)) d4 (
      .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[4]), .valida(valida[4]), .clr_req(clr_req), .busy(busy[4]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic acc(input logic e, input logic [3:0] w, input logic [6:0] a, input logic [31:0] d);
      ena   = e;
      wea   = w;
      addra = a;
      dina  = d;
   endtask

   initial begin
      rsta_n = 1'b0; clr_req = 1'b0;
      acc(1'b0, 4'h0, 7'd0, 32'h0);

      // reset
      tick();
      chk("rst_busy0", {31'b0, busy[0]}, 32'd1);
      chk("rst_busy4", {31'b0, busy[4]}, 32'd0);
      chk("rst_dout0", douta[0], 32'h0);
      chk("rst_val0", {31'b0, valida[0]}, 32'd0);
      chk("rst_dout3", douta[3], 32'h0);
      chk("rst_val3", {31'b0, valida[3]}, 32'd0);
      rsta_n = 1'b1;

      // clear after reset lasts exactly DEPTH cycles
      n = 0;
      while (busy[0] && n < 300) begin tick(); n++; end
      chk("clr_len_rst", n, 32'd128);

      // reads of cleared words, first one in the first non-busy cycle
      acc(1'b1, 4'h0, 7'd0, 32'h0);   tick();
      chk("rd0_d", douta[0], 32'h0);  chk("rd0_v", {31'b0, valida[0]}, 32'd1);
      acc(1'b1, 4'h0, 7'd64, 32'h0);  tick();
      chk("rd64_d", douta[0], 32'h0); chk("rd64_v", {31'b0, valida[0]}, 32'd1);
      acc(1'b1, 4'h0, 7'd127, 32'h0); tick();
      chk("rd127_d", douta[0], 32'h0); chk("rd127_v", {31'b0, valida[0]}, 32'd1);

      // byte-enable merge at address 5
      acc(1'b1, 4'hF, 7'd5, 32'hDEADBEEF); tick();
      chk("w5_rf_old", douta[0], 32'h0);
      chk("w5_wf_new", douta[1], 32'hDEADBEEF);
      chk("w5_nc_v", {31'b0, valida[2]}, 32'd0);
      acc(1'b1, 4'b0010, 7'd5, 32'h00005500); tick();
      chk("w5b_rf_old", douta[0], 32'hDEADBEEF);
      chk("w5b_wf_mrg", douta[1], 32'hDEAD55EF);
      acc(1'b1, 4'h0, 7'd5, 32'h0); tick();
      chk("r5_d0", douta[0], 32'hDEAD55EF);
      chk("r5_v0", {31'b0, valida[0]}, 32'd1);
      chk("r5_d2", douta[2], 32'hDEAD55EF);

      // read-during-write modes at address 9
      acc(1'b1, 4'hF, 7'd9, 32'h11111111); tick();
      acc(1'b1, 4'hF, 7'd9, 32'h22222222); tick();
      chk("rdw_rf_d", douta[0], 32'h11111111); chk("rdw_rf_v", {31'b0, valida[0]}, 32'd1);
      chk("rdw_wf_d", douta[1], 32'h22222222); chk("rdw_wf_v", {31'b0, valida[1]}, 32'd1);
      chk("rdw_nc_d", douta[2], 32'hDEAD55EF); chk("rdw_nc_v", {31'b0, valida[2]}, 32'd0);
      acc(1'b0, 4'h0, 7'd9, 32'h0); tick();
      chk("idle_v0", {31'b0, valida[0]}, 32'd0);
      chk("idle_hold0", douta[0], 32'h11111111);
      acc(1'b1, 4'h0, 7'd9, 32'h0); tick();
      chk("r9_nc", douta[2], 32'h22222222);

      // output-register latency with back-to-back reads
      acc(1'b1, 4'hF, 7'd1, 32'h01010101); tick();
      acc(1'b1, 4'hF, 7'd2, 32'h02020202); tick();
      acc(1'b1, 4'hF, 7'd3, 32'h03030303); tick();
      acc(1'b0, 4'h0, 7'd0, 32'h0); tick(); tick();
      acc(1'b1, 4'h0, 7'd1, 32'h0); tick();
      chk("or_e1_v", {31'b0, valida[3]}, 32'd0);
      acc(1'b1, 4'h0, 7'd2, 32'h0); tick();
      chk("or_e2_v", {31'b0, valida[3]}, 32'd1); chk("or_e2_d", douta[3], 32'h01010101);
      acc(1'b1, 4'h0, 7'd3, 32'h0); tick();
      chk("or_e3_v", {31'b0, valida[3]}, 32'd1); chk("or_e3_d", douta[3], 32'h02020202);
      acc(1'b0, 4'h0, 7'd0, 32'h0); tick();
      chk("or_e4_v", {31'b0, valida[3]}, 32'd1); chk("or_e4_d", douta[3], 32'h03030303);
      tick();
      chk("or_e5_v", {31'b0, valida[3]}, 32'd0); chk("or_e5_d", douta[3], 32'h03030303);

      // clr_req pulse; accesses dropped while busy, repeated requests ignored
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      chk("clr_busy", {31'b0, busy[0]}, 32'd1);
      chk("clr_busy4", {31'b0, busy[4]}, 32'd1);
      acc(1'b1, 4'hF, 7'd5, 32'hFFFFFFFF);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("busy_drop_v", {31'b0, valida[0]}, 32'd0);
      end
      acc(1'b0, 4'h0, 7'd0, 32'h0);
      clr_req = 1'b1;
      for (int i = 0; i < 36; i++) tick();
      clr_req = 1'b0;

      // reset at clear cycle 40 restarts the clear
      rsta_n = 1'b0; tick(); rsta_n = 1'b1;
      chk("mid_rst_busy", {31'b0, busy[0]}, 32'd1);
      chk("mid_rst_busy4", {31'b0, busy[4]}, 32'd0);
      chk("mid_rst_dout0", douta[0], 32'h0);
      chk("mid_rst_dout3", douta[3], 32'h0);
      n = 0;
      while (busy[0] && n < 300) begin tick(); n++; end
      chk("clr_len_mid", n, 32'd128);
      acc(1'b1, 4'h0, 7'd5, 32'h0); tick();
      chk("r5_cleared", douta[0], 32'h0); chk("r5_cleared_v", {31'b0, valida[0]}, 32'd1);

      // clr_req with a same-cycle write: write lands, clear follows
      acc(1'b1, 4'hF, 7'd3, 32'hA5A5A5A5); clr_req = 1'b1; tick();
      clr_req = 1'b0; acc(1'b0, 4'h0, 7'd0, 32'h0);
      chk("cw_wf_d", douta[1], 32'hA5A5A5A5); chk("cw_wf_v", {31'b0, valida[1]}, 32'd1);
      chk("cw_busy", {31'b0, busy[0]}, 32'd1);
      n = 0;
      while (busy[0] && n < 300) begin tick(); n++; end
      chk("clr_len_req", n, 32'd128);
      acc(1'b1, 4'h0, 7'd3, 32'h0); tick();
      chk("r3_cleared", douta[0], 32'h0); chk("r3_cleared_v", {31'b0, valida[0]}, 32'd1);
      acc(1'b0, 4'h0, 7'd0, 32'h0); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/block_ram_bytewise.md
# block_ram_bytewise

Parametrised single-port synchronous block RAM with per-byte write enables, selectable read-during-write behaviour, optional output register and a hardware clear sequencer. It is the next generation of the pipeline's instruction/data block RAM. It serves the fetch and memory stages through one port, with data width, depth and latency set per instance. A clear sequencer zeroes the array after reset or on request, so simulation and FPGA start from identical memory contents.

## Interface
- DATA_W, 32, data width; must be a multiple of 8
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W words
- OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
- WR_MODE, 0, 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- CLEAR_ON_RESET, 1, 1: reset launches the clear sequence; 0: reset leaves contents untouched
- clka  in  1  clock; all logic is on the rising edge
- rsta_n  in  1  reset, synchronous, active-low
- ena  in  1  access request
- wea  in  DATA_W/8  byte write enables; bit i covers dina[8i+7:8i]
- addra  in  ADDR_W  word address
- dina  in  DATA_W  write data
- douta  out  DATA_W  read data
- valida  out  1  douta carries the result of the access accepted LAT cycles earlier
- clr_req  in  1  request a full clear (single-cycle pulse or level)
- busy  out  1  clear in progress; accesses are not accepted

## Operation
- Accept condition: ena && !busy. Requests while busy are dropped, with no write and no valida.
- Write: each byte i with wea[i]=1 is updated at addra. Bytes with wea[i]=0 are preserved.
- Read-only access (wea=0): douta = mem[addra].
- Access with any wea bit set:
  - READ_FIRST: douta = old word.
  - WRITE_FIRST: douta = merged new word (new bytes where wea=1, old bytes elsewhere).
  - NO_CHANGE: douta holds its previous value and valida stays 0.
- douta holds its last value when no access is accepted.
- Clear FSM states:
  - IDLE → CLEAR on clr_req, or on reset when CLEAR_ON_RESET=1.
  - CLEAR writes 0 to addresses 0..DEPTH-1 in ascending order, one word per cycle, using a counter of ADDR_W bits.
  - CLEAR → IDLE after writing address DEPTH-1 (counter wrap).
  - busy = (state == CLEAR).
- clr_req while busy is ignored and does not extend the clear.
- clr_req and ena in the same IDLE cycle: the access is accepted; the clear starts on the next cycle.

## Timing
- Reset (rsta_n low at an edge):
  - douta = 0, valida = 0, all pipeline valid bits = 0, counter = 0.
  - state = CLEAR if CLEAR_ON_RESET=1, else IDLE; busy follows state.
  - Memory contents are not reset directly.
- Reset mid-clear restarts the clear at address 0.
- Reset mid-read discards pending valids.
- Read latency LAT = 1 + OUT_REG. An accept at edge k gives douta/valida at edge k+LAT.
- valida is a one-cycle pulse per accepted access. Back-to-back accesses give one result per cycle at full throughput.
- Clear duration is exactly DEPTH cycles. busy falls on the edge after address DEPTH-1 is written. An access can be accepted in the cycle busy is first low.
- Write then read of the same address on consecutive cycles returns the new data in every mode.

## Structure
- Package block_ram_pkg: WR_MODE constants (READ_FIRST, WRITE_FIRST, NO_CHANGE) and the clear FSM state type (IDLE, CLEAR).
- Sub-module block_ram_clear_seq: FSM, address counter and busy. It drives a write-port override of address, all-ones byte enable and zero data into the array.
- Top level: array, byte-merge logic, read-mode mux, optional output register, valid pipeline.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=7 → busy high for exactly 128 cycles; then reading addresses 0, 64 and 127 returns 0x00000000 with valida one cycle later.
- Write 0xDEADBEEF to 5 with wea=4'hF, then wea=4'b0010 with dina=0x00005500 → read of 5 returns 0xDEAD55EF.
- Preload 0x11111111 at 9; write 0x22222222 to 9 with a concurrent read → READ_FIRST douta=0x11111111 with valida=1; WRITE_FIRST douta=0x22222222; NO_CHANGE douta unchanged with valida=0.
- OUT_REG=1, back-to-back reads of addresses 1, 2, 3 → valida high on edges k+2, k+3, k+4 with matching data.
- clr_req pulse, then ena reads issued during busy → no valida. Reset asserted at clear cycle 40 → busy stays high and the clear restarts, completing 128 cycles after reset release.
- clr_req together with a write of 0xA5A5A5A5 to 3 in IDLE → the write lands, the clear follows, and a read of 3 afterwards returns 0.
